seq_divider: RTL and testbench

- Iterative 32-bit signed restoring divider for the ALU DIV operation.
- Sits directly downstream of the subtractor datapath: each iteration consumes one trial subtraction (partial remainder minus divisor).
- Produces the 64-bit {remainder, quotient} word that the Z register captures, with HI = remainder and LO = quotient.
- Multi-cycle with a start/done handshake; the control unit stalls on busy.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 113 +++++++++++
 tb/tb_seq_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared definitions for the iterative ALU divider: FSM state encoding,
//   the DIV opcode constant and the default operand width.
package seq_divider_pkg;

  localparam int          DEF_WIDTH = 32;
  localparam logic [5:0]  OP_DIV    = 6'h1A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step
//   One restoring-division iteration. It forms the trial subtraction of the
//   divisor from the already-shifted partial remainder at WIDTH+1 bits. If
//   the trial is non-negative it is kept; otherwise the old value is restored.
// Ports:
//   i_rem_sh   shifted partial remainder {rem[W-2:0], quo[W-1]}
//   i_divisor  |divisor|, which may be 2^(W-1) when the operand is the most negative value
//   o_rem      next partial remainder
//   o_qbit     quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem_sh,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_trial;

  // The extra top bit is the borrow. Both operands are unsigned magnitudes,
  // so a |divisor| of 2^(W-1) still compares correctly.
  assign w_trial = {1'b0, i_rem_sh} - {1'b0, i_divisor};
  assign o_qbit  = ~w_trial[WIDTH];
  assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : i_rem_sh;

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Iterative signed restoring divider for ALU DIV. It divides magnitudes one
//   bit per clock, then fixes up the signs (C semantics: the quotient
//   truncates toward zero and the remainder takes the sign of the dividend).
// Ports:
//   clk          rising-edge clock
//   clr          synchronous active-low clear
//   start        request; sampled only in IDLE
//   dividend     signed dividend, sampled on accept
//   divisor      signed divisor, sampled on accept
//   busy         operation in flight (accept+1 .. done)
//   done         one-cycle pulse; result and div_by_zero are valid with it
//   div_by_zero  the last operation had a zero divisor
//   result       {remainder, quotient}; holds until the next done
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q, r_sign_r, r_dbz;

  logic [WIDTH-1:0] w_rem_sh, w_rem_nxt, w_abs_dvd, w_abs_dvs;
  logic [WIDTH-1:0] w_fix_rem, w_fix_quo;
  logic             w_qbit;

  assign w_abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
  assign w_rem_sh  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem_sh  (w_rem_sh),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // On divide-by-zero the quotient register still holds |dividend|.
  // Applying the remainder sign fix to it gives back the original dividend,
  // so no extra register is needed for the raw operand.
  always_comb begin
    w_fix_quo = r_sign_q ? (~r_quo + 1'b1) : r_quo;
    w_fix_rem = r_sign_r ? (~r_rem + 1'b1) : r_rem;
    if (r_dbz) begin
      w_fix_quo = '1;
      w_fix_rem = r_sign_r ? (~r_quo + 1'b1) : r_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_quo    <= w_abs_dvd;
            r_dvs    <= w_abs_dvs;
            r_rem    <= '0;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_cnt    <= CW'(WIDTH);
            busy     <= 1'b1;
            r_dbz    <= (divisor == '0);
            r_state  <= (divisor == '0) ? ST_FIX : ST_ITER;
          end
        end
        ST_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          result      <= {w_fix_rem, w_fix_quo};
          div_by_zero <= r_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // C-semantics reference: signed 64-bit division truncates toward zero, and
  // % takes the sign of the dividend. INT_MIN / -1 wraps when it is cut to 32 bits.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    q32 = q[31:0];
    r32 = r[31:0];
    return {r32, q32};
  endfunction

  // Issue one request and wait for done. lat is the number of rising edges
  // after the accept edge until done is seen. The wait is bounded, and on
  // timeout lat is left at 100.
  task automatic run(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [63:0] held, exp;
    logic [31:0] a, b;

    tv[0]  = '{32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, 33};
    tv[1]  = '{32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 1'b0, 33};
    tv[2]  = '{32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 1'b0, 33};
    tv[3]  = '{32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0, 33};
    tv[4]  = '{32'h80000000,   32'd1,          64'h00000000_80000000, 1'b0, 33};
    tv[5]  = '{32'd1234,       32'd0,          64'h000004D2_FFFFFFFF, 1'b1, 1};
    tv[6]  = '{32'd9,          32'd3,          64'h00000000_00000003, 1'b0, 33};
    tv[7]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 1'b0, 33};
    tv[8]  = '{32'd7,          32'd100,        64'h00000007_00000000, 1'b0, 33};
    tv[9]  = '{32'd0,          32'd5,          64'h00000000_00000000, 1'b0, 33};
    tv[10] = '{32'hFFFFFB2E,   32'd0,          64'hFFFFFB2E_FFFFFFFF, 1'b1, 1};
    tv[11] = '{32'h80000000,   32'h80000000,   64'h00000000_00000001, 1'b0, 33};
    tv[12] = '{32'hFFFFFFFF,   32'h80000000,   64'hFFFFFFFF_00000000, 1'b0, 33};

    clr = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz",  64'(div_by_zero), 64'd0);
    chk("rst_result", result, 64'd0);
    clr = 1'b1;

    // Directed table
    foreach (tv[i]) begin
      run(tv[i].a, tv[i].b, lat);
      chk($sformatf("tv%0d_lat", i),    64'(lat), 64'(tv[i].lat));
      chk($sformatf("tv%0d_result", i), result, tv[i].exp);
      chk($sformatf("tv%0d_dbz", i),    64'(div_by_zero), 64'(tv[i].dbz));
    end

    // start pulse while busy is ignored; the operation keeps its operands
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (9) begin @(negedge clk); lat++; end
    dividend = 32'd5; divisor = 32'd5; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("busy_start_lat", 64'(lat), 64'd33);
    chk("busy_start_result", result, 64'h00000002_0000000E);
    @(negedge clk);
    chk("no_reaccept_busy", 64'(busy), 64'd0);

    // clr in the middle of a division aborts it
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", result, 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_result_hold", result, 64'd0);
    run(32'd9, 32'd3, lat);
    chk("after_abort_lat", 64'(lat), 64'd33);
    chk("after_abort_result", result, 64'h00000000_00000003);

    // Randomized signed pairs against the arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = -32'($urandom_range(1, 20));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd1;
      if (n % 50 == 0) a = 32'h80000000;
      exp = ref_div(a, b);
      run(a, b, lat);
      chk($sformatf("rnd%0d_lat a=%h b=%h", n, a, b), 64'(lat), 64'd33);
      chk($sformatf("rnd%0d_result a=%h b=%h", n, a, b), result, exp);
      chk($sformatf("rnd%0d_dbz", n), 64'(div_by_zero), 64'd0);
      held = result;
      @(negedge clk);
      chk($sformatf("rnd%0d_done_width", n), 64'(done), 64'd0);
      chk($sformatf("rnd%0d_hold", n), result, held);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
